alu_share_ctrl: RTL

- Round-robin scheduler that shares the single 16-bit datapath ALU between two requesters.
- The two requesters are the instruction-sequencing path (port 0) and a debug/self-test path (port 1).
- Each requester presents an op and two operands with a valid/ready handshake. The block drives the ALU's data1/data2/ALUcontrol inputs from registered values, captures ALUresult/zero, and returns them on a per-requester response handshake.
- The ALU itself stays external and purely combinational.

---
 rtl/alu_share_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler that shares one external combinational ALU between two
// requesters. Only one op is in flight at a time: IDLE -> EXEC -> RESP.
module alu_share_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_data1,
   output logic [WIDTH-1:0] alu_data2,
   output logic [1:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   state_t state;
   state_t state_nxt;
   logic   last_grant;
   logic   owner;
   logic   grant0;
   logic   grant1;
   logic   owner_rsp_ready;

   // On a tie the port that did not win last time is granted.
   assign grant0 = req0_valid && (!req1_valid || last_grant);
   assign grant1 = req1_valid && (!req0_valid || !last_grant);

   assign req0_ready      = (state == IDLE) && grant0;
   assign req1_ready      = (state == IDLE) && grant1;
   assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) && owner;
   assign busy       = (state != IDLE);

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (grant0 || grant1) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (owner_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         alu_data1   <= '0;
         alu_data2   <= '0;
         alu_control <= OP_ILLEGAL;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready) begin
                  alu_control <= req0_op;
                  alu_data1   <= req0_a;
                  alu_data2   <= req0_b;
                  owner       <= 1'b0;
                  last_grant  <= 1'b0;
               end else if (req1_ready) begin
                  alu_control <= req1_op;
                  alu_data1   <= req1_a;
                  alu_data2   <= req1_b;
                  owner       <= 1'b1;
                  last_grant  <= 1'b1;
               end
            end
            EXEC: begin
               // An illegal op reports an error with a clean zero result/flag.
               rsp_err <= (alu_control == OP_ILLEGAL);
               if (alu_control == OP_ILLEGAL) begin
                  rsp_result <= '0;
                  rsp_zero   <= 1'b0;
               end else begin
                  rsp_result <= alu_result;
                  rsp_zero   <= alu_zero;
               end
            end
            RESP: begin
               if (owner_rsp_ready) alu_control <= OP_ILLEGAL;
            end
            default: ;
         endcase
      end
   end

endmodule
